// File: rtl/alu_issue_scheduler_pkg.sv
// Shared widths, opcode encodings and the reservation-entry layout for the ALU issue scheduler.
package alu_issue_scheduler_pkg;

  localparam int IDWidth       = 32;
  localparam int AddressWidth  = 32;
  localparam int ROBWidth      = 4;
  localparam int InstTypeWidth = 6;

  localparam logic [InstTypeWidth-1:0] NOP     = 6'd0;
  localparam logic [InstTypeWidth-1:0] OP_ADD  = 6'd1;
  localparam logic [InstTypeWidth-1:0] OP_SUB  = 6'd2;
  localparam logic [InstTypeWidth-1:0] OP_ADDI = 6'd3;
  localparam logic [InstTypeWidth-1:0] OP_AND  = 6'd4;
  localparam logic [InstTypeWidth-1:0] OP_OR   = 6'd5;
  localparam logic [InstTypeWidth-1:0] OP_XOR  = 6'd6;
  localparam logic [InstTypeWidth-1:0] OP_SLL  = 6'd7;
  localparam logic [InstTypeWidth-1:0] OP_SRL  = 6'd8;
  localparam logic [InstTypeWidth-1:0] OP_SLT  = 6'd9;
  localparam logic [InstTypeWidth-1:0] OP_LUI  = 6'd10;

  typedef struct packed {
    logic                     valid;
    logic [InstTypeWidth-1:0] opcode;
    logic [IDWidth-1:0]       vj;
    logic [ROBWidth-1:0]      qj;
    logic [IDWidth-1:0]       vk;
    logic [ROBWidth-1:0]      qk;
    logic [IDWidth-1:0]       a;
    logic [AddressWidth-1:0]  pc;
    logic [ROBWidth-1:0]      dest;
  } rs_entry_t;

  // Tag 0 means "operand present", so it can never match a broadcast.
  function automatic logic tag_hit(input logic [ROBWidth-1:0] q,
                                   input logic                cdb_valid,
                                   input logic [ROBWidth-1:0] cdb_tag);
    return cdb_valid && (cdb_tag != '0) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_picker.sv
// Oldest-ready select: age_in[j][i]=1 means entry j was allocated before entry i.
module rs_oldest_picker #(
  parameter int ENTRIES = 8
) (
  input  logic [ENTRIES-1:0]              ready_in,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] age_in,
  output logic [ENTRIES-1:0]              grant_out,
  output logic                            valid_out
);

  always_comb begin
    grant_out = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      grant_out[i] = ready_in[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && ready_in[j] && age_in[j][i]) grant_out[i] = 1'b0;
      end
    end
  end

  assign valid_out = |ready_in;

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: allocates decoded ops, wakes them from the CDB and issues the oldest ready one per cycle.
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     dec_valid_in,
  input  logic [InstTypeWidth-1:0] dec_opcode_in,
  input  logic [IDWidth-1:0]       dec_vj_in,
  input  logic [IDWidth-1:0]       dec_vk_in,
  input  logic [ROBWidth-1:0]      dec_qj_in,
  input  logic [ROBWidth-1:0]      dec_qk_in,
  input  logic [IDWidth-1:0]       dec_a_in,
  input  logic [AddressWidth-1:0]  dec_pc_in,
  input  logic [ROBWidth-1:0]      dec_dest_in,
  output logic                     full_out,
  input  logic                     cdb_valid_in,
  input  logic [ROBWidth-1:0]      cdb_tag_in,
  input  logic [IDWidth-1:0]       cdb_value_in,
  input  logic                     rob_rst_in,
  output logic [InstTypeWidth-1:0] alu_opcode_out,
  output logic [IDWidth-1:0]       alu_vj_out,
  output logic [IDWidth-1:0]       alu_vk_out,
  output logic [IDWidth-1:0]       alu_a_out,
  output logic [AddressWidth-1:0]  alu_pc_out,
  output logic [ROBWidth-1:0]      alu_dest_out
);

  localparam int IdxW = $clog2(ENTRIES);

  rs_entry_t                     r_ent [ENTRIES];
  logic [ENTRIES-1:0][ENTRIES-1:0] r_age;

  logic [ENTRIES-1:0] w_valid;
  logic [ENTRIES-1:0] w_ready;
  logic [ENTRIES-1:0] w_grant;
  logic               w_any;
  logic [IdxW-1:0]    w_alloc_idx;
  logic               w_alloc;
  rs_entry_t          w_sel;
  rs_entry_t          w_new;

  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_ready[i] = r_ent[i].valid && (r_ent[i].qj == '0) && (r_ent[i].qk == '0);
    end
  end

  assign full_out = &w_valid;
  assign w_alloc  = dec_valid_in && !full_out;

  // Lowest free slot of the current state; a slot freed by this edge's issue is still valid here.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_alloc_idx = IdxW'(i);
    end
  end

  rs_oldest_picker #(.ENTRIES(ENTRIES)) u_picker (
    .ready_in  (w_ready),
    .age_in    (r_age),
    .grant_out (w_grant),
    .valid_out (w_any)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_grant[i]) w_sel = r_ent[i];
    end
  end

  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.opcode = dec_opcode_in;
    w_new.vj     = dec_vj_in;
    w_new.qj     = dec_qj_in;
    w_new.vk     = dec_vk_in;
    w_new.qk     = dec_qk_in;
    w_new.a      = dec_a_in;
    w_new.pc     = dec_pc_in;
    w_new.dest   = dec_dest_in;
    if (tag_hit(dec_qj_in, cdb_valid_in, cdb_tag_in)) begin
      w_new.vj = cdb_value_in;
      w_new.qj = '0;
    end
    if (tag_hit(dec_qk_in, cdb_valid_in, cdb_tag_in)) begin
      w_new.vk = cdb_value_in;
      w_new.qk = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
      r_age          <= '0;
      alu_opcode_out <= NOP;
      alu_vj_out     <= '0;
      alu_vk_out     <= '0;
      alu_a_out      <= '0;
      alu_pc_out     <= '0;
      alu_dest_out   <= '0;
    end else if (rdy_in) begin
      if (rob_rst_in) begin
        for (int i = 0; i < ENTRIES; i++) r_ent[i].valid <= 1'b0;
        r_age          <= '0;
        alu_opcode_out <= NOP;
        alu_vj_out     <= '0;
        alu_vk_out     <= '0;
        alu_a_out      <= '0;
        alu_pc_out     <= '0;
        alu_dest_out   <= '0;
      end else begin
        alu_opcode_out <= w_any ? w_sel.opcode : NOP;
        alu_vj_out     <= w_any ? w_sel.vj     : '0;
        alu_vk_out     <= w_any ? w_sel.vk     : '0;
        alu_a_out      <= w_any ? w_sel.a      : '0;
        alu_pc_out     <= w_any ? w_sel.pc     : '0;
        alu_dest_out   <= w_any ? w_sel.dest   : '0;

        for (int i = 0; i < ENTRIES; i++) begin
          if (r_ent[i].valid) begin
            if (tag_hit(r_ent[i].qj, cdb_valid_in, cdb_tag_in)) begin
              r_ent[i].vj <= cdb_value_in;
              r_ent[i].qj <= '0;
            end
            if (tag_hit(r_ent[i].qk, cdb_valid_in, cdb_tag_in)) begin
              r_ent[i].vk <= cdb_value_in;
              r_ent[i].qk <= '0;
            end
          end
          if (w_grant[i]) r_ent[i].valid <= 1'b0;
        end

        // New entry becomes younger than every other slot; stale rows of free slots are masked by ready.
        if (w_alloc) begin
          r_ent[w_alloc_idx] <= w_new;
          for (int j = 0; j < ENTRIES; j++) begin
            r_age[j][w_alloc_idx] <= (j != int'(w_alloc_idx));
            r_age[w_alloc_idx][j] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scenario bench for alu_issue_scheduler against an in-order queue model of the reservation station.
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  localparam int ENTRIES = 8;
  localparam int OW = InstTypeWidth + 4 * IDWidth + ROBWidth;

  logic                     clk_in = 1'b0;
  logic                     rst_in, rdy_in, dec_valid_in, cdb_valid_in, rob_rst_in;
  logic [InstTypeWidth-1:0] dec_opcode_in;
  logic [IDWidth-1:0]       dec_vj_in, dec_vk_in, dec_a_in, cdb_value_in;
  logic [ROBWidth-1:0]      dec_qj_in, dec_qk_in, dec_dest_in, cdb_tag_in;
  logic [AddressWidth-1:0]  dec_pc_in;
  logic                     full_out;
  logic [InstTypeWidth-1:0] alu_opcode_out;
  logic [IDWidth-1:0]       alu_vj_out, alu_vk_out, alu_a_out;
  logic [AddressWidth-1:0]  alu_pc_out;
  logic [ROBWidth-1:0]      alu_dest_out;
  logic [OW-1:0]            w_out;

  int checks   = 0;
  int failures = 0;

  alu_issue_scheduler #(.ENTRIES(ENTRIES)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid_in(dec_valid_in), .dec_opcode_in(dec_opcode_in),
    .dec_vj_in(dec_vj_in), .dec_vk_in(dec_vk_in), .dec_qj_in(dec_qj_in), .dec_qk_in(dec_qk_in),
    .dec_a_in(dec_a_in), .dec_pc_in(dec_pc_in), .dec_dest_in(dec_dest_in), .full_out(full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .rob_rst_in(rob_rst_in), .alu_opcode_out(alu_opcode_out), .alu_vj_out(alu_vj_out),
    .alu_vk_out(alu_vk_out), .alu_a_out(alu_a_out), .alu_pc_out(alu_pc_out),
    .alu_dest_out(alu_dest_out)
  );

  assign w_out = {alu_opcode_out, alu_vj_out, alu_vk_out, alu_a_out, alu_pc_out, alu_dest_out};

  always #5 clk_in = ~clk_in;

  // Reference: entries kept in allocation order, so "oldest ready" is simply the first ready one.
  typedef struct {
    logic [InstTypeWidth-1:0] op;
    logic [IDWidth-1:0]       vj, vk, a;
    logic [AddressWidth-1:0]  pc;
    logic [ROBWidth-1:0]      qj, qk, dest;
  } m_ent_t;

  m_ent_t        mq[$];
  logic [OW-1:0] exp_out;

  function automatic void model_reset();
    mq.delete();
    exp_out = '0;
  endfunction

  function automatic void model_edge();
    int     pre, idx;
    m_ent_t e;
    if (!rdy_in) return;
    if (rob_rst_in) begin
      model_reset();
      return;
    end
    pre = mq.size();
    idx = -1;
    for (int i = 0; i < mq.size(); i++)
      if (idx < 0 && mq[i].qj == 0 && mq[i].qk == 0) idx = i;
    if (idx >= 0) begin
      exp_out = {mq[idx].op, mq[idx].vj, mq[idx].vk, mq[idx].a, mq[idx].pc, mq[idx].dest};
      mq.delete(idx);
    end else exp_out = '0;
    if (cdb_valid_in && cdb_tag_in != 0) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].qj == cdb_tag_in) begin mq[i].vj = cdb_value_in; mq[i].qj = 0; end
        if (mq[i].qk == cdb_tag_in) begin mq[i].vk = cdb_value_in; mq[i].qk = 0; end
      end
    end
    if (dec_valid_in && pre < ENTRIES) begin
      e = '{op: dec_opcode_in, vj: dec_vj_in, vk: dec_vk_in, a: dec_a_in, pc: dec_pc_in,
            qj: dec_qj_in, qk: dec_qk_in, dest: dec_dest_in};
      if (cdb_valid_in && cdb_tag_in != 0 && e.qj == cdb_tag_in) begin e.vj = cdb_value_in; e.qj = 0; end
      if (cdb_valid_in && cdb_tag_in != 0 && e.qk == cdb_tag_in) begin e.vk = cdb_value_in; e.qk = 0; end
      mq.push_back(e);
    end
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; dec_valid_in = 1'b0; cdb_valid_in = 1'b0; rob_rst_in = 1'b0;
    cdb_tag_in = '0; cdb_value_in = '0;
  endtask

  task automatic set_dec(input logic [InstTypeWidth-1:0] op, input logic [31:0] vj,
                         input logic [3:0] qj, input logic [31:0] vk, input logic [3:0] qk,
                         input logic [31:0] a, input logic [31:0] pc, input logic [3:0] dest);
    dec_valid_in = 1'b1; dec_opcode_in = op; dec_vj_in = vj; dec_qj_in = qj;
    dec_vk_in = vk; dec_qk_in = qk; dec_a_in = a; dec_pc_in = pc; dec_dest_in = dest;
  endtask

  task automatic test_reset();
    idle();
    set_dec(OP_ADD, 0, 0, 0, 0, 0, 0, 1);
    dec_valid_in = 1'b0;
    rst_in = 1'b1;
    model_reset();
    #2;
    checks++;
    if (w_out !== '0 || full_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out=%h full=%b expected out=0 full=0", w_out, full_out);
    end
    @(negedge clk_in); rst_in = 1'b0;
    cyc();
    checks++;
    if (w_out !== exp_out || alu_opcode_out !== NOP) begin
      failures++;
      $display("FAIL reset_idle out=%h expected %h", w_out, exp_out);
    end
  endtask

  task automatic test_addi();
    set_dec(OP_ADDI, 5, 0, 0, 0, 7, 32'h100, 3);
    cyc();
    checks++;
    if (w_out !== exp_out) begin
      failures++; $display("FAIL addi_alloc_edge out=%h expected %h", w_out, exp_out);
    end
    idle(); cyc();
    checks++;
    if (alu_opcode_out !== OP_ADDI || alu_vj_out !== 32'd5 || alu_a_out !== 32'd7 ||
        alu_dest_out !== 4'd3 || w_out !== exp_out) begin
      failures++;
      $display("FAIL addi_issue op=%0d vj=%0d a=%0d dest=%0d expected op=%0d vj=5 a=7 dest=3",
               alu_opcode_out, alu_vj_out, alu_a_out, alu_dest_out, OP_ADDI);
    end
    cyc();
    checks++;
    if (alu_opcode_out !== NOP || w_out !== exp_out) begin
      failures++; $display("FAIL addi_after out=%h expected %h", w_out, exp_out);
    end
  endtask

  task automatic test_wakeup();
    set_dec(OP_ADD, 0, 2, 9, 0, 0, 32'h104, 4);
    cyc();
    idle(); cdb_valid_in = 1'b1; cdb_tag_in = 4'd2; cdb_value_in = 32'h10;
    cyc();
    checks++;
    if (alu_opcode_out !== NOP || w_out !== exp_out) begin
      failures++; $display("FAIL wakeup_early out=%h expected %h", w_out, exp_out);
    end
    idle(); cyc();
    checks++;
    if (alu_opcode_out !== OP_ADD || alu_vj_out !== 32'h10 || alu_vk_out !== 32'd9 ||
        alu_dest_out !== 4'd4 || w_out !== exp_out) begin
      failures++; $display("FAIL wakeup_issue out=%h expected %h", w_out, exp_out);
    end
    cyc();
  endtask

  task automatic test_oldest();
    set_dec(OP_SUB, 0, 1, 3, 0, 0, 32'h200, 5); cyc();
    set_dec(OP_XOR, 1, 0, 2, 0, 0, 32'h204, 6); cyc();
    idle(); cdb_valid_in = 1'b1; cdb_tag_in = 4'd1; cdb_value_in = 32'h55;
    cyc();
    checks++;
    if (alu_dest_out !== 4'd6 || w_out !== exp_out) begin
      failures++; $display("FAIL oldest_first dest=%0d expected 6", alu_dest_out);
    end
    idle(); cyc();
    checks++;
    if (alu_dest_out !== 4'd5 || alu_vj_out !== 32'h55 || w_out !== exp_out) begin
      failures++; $display("FAIL oldest_second dest=%0d vj=%h expected dest=5 vj=55", alu_dest_out, alu_vj_out);
    end
    cyc();
  endtask

  task automatic test_full();
    for (int k = 0; k < ENTRIES; k++) begin
      set_dec(OP_AND, k, (k == 0) ? 4'd9 : 4'd10, 0, 0, 0, 32'h300 + k, 4'(k + 1));
      cyc();
    end
    checks++;
    if (full_out !== 1'b1 || mq.size() != ENTRIES) begin
      failures++; $display("FAIL full_set full=%b expected 1", full_out);
    end
    set_dec(OP_OR, 1, 0, 1, 0, 0, 32'h3ff, 15);
    cyc();
    checks++;
    if (full_out !== 1'b1 || w_out !== exp_out || alu_opcode_out !== NOP) begin
      failures++; $display("FAIL full_ignore full=%b out=%h expected full=1 out=%h", full_out, w_out, exp_out);
    end
    idle(); cdb_valid_in = 1'b1; cdb_tag_in = 4'd9; cdb_value_in = 32'h99;
    cyc();
    checks++;
    if (full_out !== 1'b1 || alu_opcode_out !== NOP) begin
      failures++; $display("FAIL full_wake full=%b op=%0d expected full=1 op=0", full_out, alu_opcode_out);
    end
    idle(); cyc();
    checks++;
    if (alu_opcode_out !== OP_AND || alu_vj_out !== 32'h99 || alu_dest_out !== 4'd1 ||
        full_out !== 1'b0 || w_out !== exp_out) begin
      failures++; $display("FAIL full_issue out=%h full=%b expected out=%h full=0", w_out, full_out, exp_out);
    end
    rob_rst_in = 1'b1; cyc(); idle();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 6; k++) begin
      set_dec(OP_SLL, k, (k < 5) ? 4'd11 : 4'd0, 0, 0, 0, 32'h400 + k, 4'(k + 1));
      cyc();
    end
    set_dec(OP_OR, 0, 0, 0, 0, 0, 32'h4ff, 7);
    rob_rst_in = 1'b1; cdb_valid_in = 1'b1; cdb_tag_in = 4'd11; cdb_value_in = 32'h77;
    cyc();
    checks++;
    if (w_out !== '0 || full_out !== 1'b0 || mq.size() != 0) begin
      failures++; $display("FAIL flush_clear out=%h full=%b expected out=0 full=0", w_out, full_out);
    end
    idle(); cdb_valid_in = 1'b1; cdb_tag_in = 4'd11; cdb_value_in = 32'h77;
    for (int c = 0; c < 4; c++) begin
      cyc();
      idle();
      checks++;
      if (w_out !== '0) begin
        failures++; $display("FAIL flush_no_issue cycle=%0d out=%h expected 0", c, w_out);
      end
    end
  endtask

  task automatic test_rdy_hold();
    set_dec(OP_SRL, 32'hA, 0, 32'hB, 0, 32'hC, 32'h500, 8); cyc();
    set_dec(OP_SLT, 32'h1, 0, 32'h2, 0, 32'h3, 32'h504, 9); cyc();
    set_dec(OP_LUI, 32'h7, 0, 0, 0, 0, 32'h508, 10);
    rdy_in = 1'b0; rob_rst_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (alu_dest_out !== 4'd8 || alu_opcode_out !== OP_SRL || w_out !== exp_out) begin
        failures++; $display("FAIL rdy_hold cycle=%0d out=%h expected %h", c, w_out, exp_out);
      end
    end
    idle(); cyc();
    checks++;
    if (alu_dest_out !== 4'd9 || alu_opcode_out !== OP_SLT || w_out !== exp_out) begin
      failures++; $display("FAIL rdy_resume out=%h expected %h", w_out, exp_out);
    end
    cyc();
  endtask

  task automatic test_bypass();
    set_dec(OP_ADD, 0, 13, 0, 13, 0, 32'h600, 11);
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd13; cdb_value_in = 32'hBEEF;
    cyc();
    idle(); cyc();
    checks++;
    if (alu_opcode_out !== OP_ADD || alu_vj_out !== 32'hBEEF || alu_vk_out !== 32'hBEEF ||
        w_out !== exp_out) begin
      failures++; $display("FAIL bypass out=%h expected %h", w_out, exp_out);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      set_dec(OP_XOR, k, (k < 3) ? 4'd12 : 4'd0, 0, 0, 0, 32'h700 + k, 4'(k + 1));
      cyc();
    end
    idle(); cyc();
    rst_in = 1'b1;
    model_reset();
    #1;
    checks++;
    if (w_out !== '0 || full_out !== 1'b0) begin
      failures++; $display("FAIL reset_mid out=%h full=%b expected 0", w_out, full_out);
    end
    @(negedge clk_in); rst_in = 1'b0;
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd12; cdb_value_in = 32'h12;
    for (int c = 0; c < 3; c++) begin
      cyc();
      idle();
      checks++;
      if (w_out !== '0) begin
        failures++; $display("FAIL reset_mid_discard cycle=%0d out=%h expected 0", c, w_out);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      rob_rst_in   = ($urandom_range(0, 49) == 0);
      dec_valid_in = ($urandom_range(0, 9) < 7);
      dec_opcode_in = 6'($urandom_range(1, 10));
      dec_vj_in = $urandom; dec_vk_in = $urandom; dec_a_in = $urandom; dec_pc_in = $urandom;
      dec_qj_in = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      dec_qk_in = $urandom_range(0, 2) != 0 ? 4'd0 : 4'($urandom_range(1, 15));
      dec_dest_in  = 4'($urandom_range(1, 15));
      cdb_valid_in = $urandom_range(0, 1);
      cdb_tag_in   = 4'($urandom_range(0, 15));
      cdb_value_in = $urandom;
      cyc();
      checks++;
      if (w_out !== exp_out || full_out !== (mq.size() == ENTRIES)) begin
        failures++;
        $display("FAIL random cycle=%0d out=%h full=%b expected out=%h full=%b",
                 c, w_out, full_out, exp_out, (mq.size() == ENTRIES));
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    idle();
    dec_opcode_in = NOP; dec_vj_in = '0; dec_vk_in = '0; dec_qj_in = '0; dec_qk_in = '0;
    dec_a_in = '0; dec_pc_in = '0; dec_dest_in = '0;
    model_reset();
    test_reset();
    test_addi();
    test_wakeup();
    test_oldest();
    test_full();
    test_flush();
    test_rdy_hold();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
